// File: rtl/gray_sched.sv
// Round-robin scheduler that lends a shared 3-bit gray counter to one of two
// requesters, runs it for the winner's step count and captures the final code.
module gray_sched (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic [3:0] Len0,
   input  logic [3:0] Len1,
   input  logic [2:0] GrayIn,
   input  logic       CntOvf,
   output logic       CntEn,
   output logic       CntClr,
   output logic [1:0] Grant,
   output logic [1:0] Done,
   output logic       Abort,
   output logic [2:0] Result,
   output logic       Wrapped,
   output logic       Busy
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t     state, state_nxt;
   logic       last;
   logic       win;
   logic [3:0] rem;
   logic       owner_req;

   // With both requesting, the one that did not win last time goes next.
   always_comb begin
      if (Req == 2'b11) win = ~last;
      else              win = Req[1];
   end

   assign owner_req = |(Grant & Req);
   assign Busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      CntEn     = 1'b0;
      CntClr    = 1'b0;
      Abort     = 1'b0;
      Done      = 2'b00;
      case (state)
         IDLE: begin
            if (Req != 2'b00) state_nxt = CLEAR;
         end
         CLEAR: begin
            CntClr = 1'b1;
            if (!owner_req) begin
               Abort     = 1'b1;
               state_nxt = IDLE;
            end else if (rem != 4'd0) begin
               state_nxt = RUN;
            end else begin
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (!owner_req) begin
               Abort     = 1'b1;
               state_nxt = IDLE;
            end else begin
               CntEn = 1'b1;
               if (rem == 4'd1) state_nxt = DONE;
            end
         end
         DONE: begin
            Done      = Grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         last    <= 1'b1;
         rem     <= 4'd0;
         Grant   <= 2'b00;
         Result  <= 3'b000;
         Wrapped <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Req != 2'b00) begin
                  Grant <= win ? 2'b10 : 2'b01;
                  last  <= win;
                  rem   <= win ? Len1 : Len0;
               end
            end
            RUN: begin
               if (CntEn) rem <= rem - 4'd1;
            end
            DONE: begin
               Result  <= GrayIn;
               Wrapped <= CntOvf;
            end
            default: ;
         endcase
         // Ownership is released on every return to IDLE, completed or aborted.
         if (state != IDLE && state_nxt == IDLE) Grant <= 2'b00;
      end
   end

endmodule

// File: tb/tb_gray_sched.sv
// Bench for gray_sched: real gray counter, timing-rule model checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_gray_sched;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] Req = 2'b00;
   logic [3:0] Len0 = 4'd0;
   logic [3:0] Len1 = 4'd0;
   logic [2:0] GrayIn;
   logic       CntOvf;
   logic       CntEn, CntClr, Abort, Wrapped, Busy;
   logic [1:0] Grant, Done;
   logic [2:0] Result;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   gray_sched dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Len0(Len0), .Len1(Len1),
      .GrayIn(GrayIn), .CntOvf(CntOvf), .CntEn(CntEn), .CntClr(CntClr),
      .Grant(Grant), .Done(Done), .Abort(Abort), .Result(Result),
      .Wrapped(Wrapped), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   // Shared counter: binary count shown as gray, sticky overflow, sync clear.
   logic [2:0] cnt = 3'd0;
   logic       ovf = 1'b0;
   always @(posedge Clk) begin
      if (CntClr) begin
         cnt <= 3'd0;
         ovf <= 1'b0;
      end else if (CntEn) begin
         cnt <= cnt + 3'd1;
         if (cnt == 3'd7) ovf <= 1'b1;
      end
   end
   assign GrayIn = cnt ^ (cnt >> 1);
   assign CntOvf = ovf;

   function automatic logic [2:0] gray3(input int v);
      logic [2:0] b;
      b = 3'(v % 8);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: k counts cycles since the grant sample (1 = clear,
   // 2..len+1 = counting, len+2 = done).
   int         m_active = 0;
   int         m_owner  = 0;
   int         m_len    = 0;
   int         m_k      = 0;
   int         m_last   = 1;
   logic [2:0] m_result = 3'd0;
   logic       m_wrapped = 1'b0;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_active  = 0;
         m_last    = 1;
         m_result  = 3'd0;
         m_wrapped = 1'b0;
      end else if (m_active != 0) begin
         if (m_k == m_len + 2) begin
            m_result  = gray3(m_len);
            m_wrapped = (m_len >= 8);
            m_active  = 0;
         end else if (!Req[m_owner]) begin
            m_active = 0;
         end else begin
            m_k++;
         end
      end else if (Req != 2'b00) begin
         m_owner  = (Req == 2'b11) ? (1 - m_last) : (Req[1] ? 1 : 0);
         m_last   = m_owner;
         m_len    = m_owner ? int'(Len1) : int'(Len0);
         m_k      = 1;
         m_active = 1;
      end
   end

   always @(negedge Clk) begin
      logic [1:0] eg, ed;
      logic       ee, ec, ea, eb;
      eg = 2'b00; ed = 2'b00; ee = 1'b0; ec = 1'b0; ea = 1'b0; eb = 1'b0;
      if (chk_en) begin
         if (Reset && m_active != 0) begin
            eg = m_owner ? 2'b10 : 2'b01;
            eb = 1'b1;
            ea = (m_k <= m_len + 1) && !Req[m_owner];
            ec = (m_k == 1);
            ee = (m_k >= 2) && (m_k <= m_len + 1) && !ea;
            ed = (m_k == m_len + 2) ? eg : 2'b00;
         end
         chk("grant",   int'(Grant),   int'(eg));
         chk("done",    int'(Done),    int'(ed));
         chk("abort",   int'(Abort),   int'(ea));
         chk("cnten",   int'(CntEn),   int'(ee));
         chk("cntclr",  int'(CntClr),  int'(ec));
         chk("busy",    int'(Busy),    int'(eb));
         chk("result",  int'(Result),  int'(m_result));
         chk("wrapped", int'(Wrapped), int'(m_wrapped));
      end
   end

   task automatic wait_done(output int lat, output int en, output int clr,
                            output logic [1:0] dn);
      lat = 0; en = 0; clr = 0;
      @(negedge Clk);
      while (Done == 2'b00 && lat < 40) begin
         if (CntEn)  en++;
         if (CntClr) clr++;
         lat++;
         @(negedge Clk);
      end
      dn = Done;
   endtask

   task automatic idle_gap();
      Req = 2'b00;
      @(posedge Clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit reached");
      $fatal(1);
   end

   initial begin
      int         lat, en, clr;
      logic [1:0] dn;

      #3 Reset = 1'b0;
      #1;
      chk("rst_grant",  int'(Grant),  0);
      chk("rst_busy",   int'(Busy),   0);
      chk("rst_result", int'(Result), 0);
      chk_en = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b1;

      // Both requesting: requester 0 first after reset, then requester 1.
      Req = 2'b11; Len0 = 4'd3; Len1 = 4'd9;
      wait_done(lat, en, clr, dn);
      chk("rr0_done", int'(dn), 1);
      chk("rr0_lat",  lat, 5);
      @(posedge Clk); #1;
      chk("rr0_result",  int'(Result),  2);
      chk("rr0_wrapped", int'(Wrapped), 0);
      wait_done(lat, en, clr, dn);
      chk("rr1_done", int'(dn), 2);
      chk("rr1_lat",  lat, 11);
      chk("rr1_en",   en, 9);
      @(posedge Clk); #1;
      chk("rr1_result",  int'(Result),  1);
      chk("rr1_wrapped", int'(Wrapped), 1);
      idle_gap();

      // Single request, five steps.
      Req = 2'b01; Len0 = 4'd5;
      wait_done(lat, en, clr, dn);
      chk("s5_done", int'(dn), 1);
      chk("s5_lat",  lat, 7);
      chk("s5_en",   en, 5);
      chk("s5_clr",  clr, 1);
      @(posedge Clk); #1;
      chk("s5_result",  int'(Result),  7);
      chk("s5_wrapped", int'(Wrapped), 0);
      chk("s5_busy",    int'(Busy),    0);
      idle_gap();

      // Owner drops its request after three counting cycles.
      Req = 2'b01; Len0 = 4'd7;
      repeat (5) @(posedge Clk);
      #1 Req = 2'b00;
      @(negedge Clk);
      chk("ab_abort", int'(Abort), 1);
      chk("ab_cnten", int'(CntEn), 0);
      chk("ab_done",  int'(Done),  0);
      @(posedge Clk); #1;
      chk("ab_busy",   int'(Busy),   0);
      chk("ab_result", int'(Result), 7);
      idle_gap();

      // Reset in the middle of a run, then a fresh double request.
      Req = 2'b10; Len1 = 4'd6;
      repeat (4) @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("mr_grant",  int'(Grant),  0);
      chk("mr_busy",   int'(Busy),   0);
      chk("mr_cnten",  int'(CntEn),  0);
      chk("mr_result", int'(Result), 0);
      Req = 2'b11; Len0 = 4'd2; Len1 = 4'd4;
      @(posedge Clk); #1 Reset = 1'b1;
      wait_done(lat, en, clr, dn);
      chk("mr_done", int'(dn), 1);
      chk("mr_lat",  lat, 4);
      @(posedge Clk); #1;
      chk("mr_result", int'(Result), 3);
      idle_gap();

      // Zero-length request goes straight from clear to done.
      Req = 2'b10; Len1 = 4'd0;
      wait_done(lat, en, clr, dn);
      chk("z_done", int'(dn), 2);
      chk("z_lat",  lat, 2);
      chk("z_en",   en, 0);
      @(posedge Clk); #1;
      chk("z_result", int'(Result), 0);
      idle_gap();

      // Maximum length; Len0 changes after the grant and must be ignored.
      Req = 2'b01; Len0 = 4'd15;
      @(posedge Clk); #1 Len0 = 4'd1;
      wait_done(lat, en, clr, dn);
      chk("m_done", int'(dn), 1);
      chk("m_lat",  lat + 1, 17);
      chk("m_en",   en, 15);
      @(posedge Clk); #1;
      chk("m_result",  int'(Result),  4);
      chk("m_wrapped", int'(Wrapped), 1);
      idle_gap();
      repeat (2) @(posedge Clk);
      #1;

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
